move_sequencer: RTL and testbench
=================================

MOVE_SEQUENCER -- requirements
Module: move_sequencer

Interface
REQ-001 SHALL have parameter DATO_WIDTH, default 3, the move-code width (matches the move FIFO data width).
REQ-002 SHALL have parameter STEPS_PER_MOVE, default 50, the step pulses per move (range 1..65535).
REQ-003 SHALL have parameter HALF_PERIOD, default 1000, the clk cycles per step half-period (range 2..65535).
REQ-004 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port fifo_dat  input  DATO_WIDTH  move code presented by the move FIFO.
REQ-007 SHALL have port fifo_empty  input  1  move FIFO holds no entries.
REQ-008 SHALL have port fifo_rd  output  1  single-cycle read strobe to the move FIFO.
REQ-009 SHALL have port step  output  4  one step line per motor; only the selected motor toggles.
REQ-010 SHALL have port dir  output  4  per-motor direction; 1 = clockwise.
REQ-011 SHALL have port busy  output  1  high from POP through the end of the last step.
REQ-012 SHALL have port done  output  1  one-cycle pulse when a move completes.
REQ-013 SHALL have port move_cnt  output  16  count of completed moves, wrapping at 65535->0.

Function
REQ-014 SHALL implement the FSM states IDLE, POP, WAIT, LOAD, STEP_HI, STEP_LO and FIN.
REQ-015 In IDLE with fifo_empty=0, the FSM SHALL go to POP on the next edge; with fifo_empty=1 it SHALL stay in IDLE.
REQ-016 In POP, fifo_rd SHALL be 1 for exactly one cycle, and the FSM SHALL then go to WAIT.
REQ-017 WAIT SHALL last one cycle (FIFO output settle), then the FSM SHALL go to LOAD.
REQ-018 LOAD SHALL capture fifo_dat into a code register: motor = code[2:1], dirbit = code[0]. It SHALL drive dir[motor] = dirbit, leave the other dir bits unchanged, clear the step counter and half-period timer, and go to STEP_HI.
REQ-019 In STEP_HI, step[motor] SHALL be 1 for exactly HALF_PERIOD cycles, then the FSM SHALL go to STEP_LO.
REQ-020 In STEP_LO, step SHALL be 0 for exactly HALF_PERIOD cycles, and the step counter SHALL increment on exit. If the count equals STEPS_PER_MOVE the FSM SHALL go to FIN, otherwise to STEP_HI.
REQ-021 FIN SHALL last one cycle: done=1, move_cnt+1, then IDLE.
REQ-022 dir SHALL change only in LOAD, never while step is high.
REQ-023 Move period SHALL be 3 + 2*HALF_PERIOD*STEPS_PER_MOVE + 1 cycles from POP entry to IDLE return.
REQ-024 Back-to-back moves: when fifo_empty=0 in IDLE right after FIN, POP SHALL begin on the next edge with no extra gap.
REQ-025 fifo_empty rising during WAIT or LOAD SHALL NOT abort the move; the captured code SHALL be executed.
REQ-026 fifo_rd SHALL never assert outside POP, nor while fifo_empty=1 is sampled in IDLE.
REQ-027 Timer and step counter SHALL be 16 bits and unsigned, with compare-equal termination and no overflow within the parameter ranges.

Reset
REQ-028 Asserting rst at any time, including mid-step, SHALL immediately force: state IDLE, fifo_rd=0, step=0, dir=0, busy=0, done=0, move_cnt=0, and clear the code register, timer and counter.
REQ-029 After rst deasserts, the first action SHALL be an IDLE evaluation on the next rising edge; a partially executed move SHALL NOT resume.

Configuration
REQ-030 Macro MOVE_SEQUENCER_PAUSE_EN, when defined, SHALL add port pause (input, 1).
REQ-031 With the macro defined and pause=1, the half-period timer SHALL hold, step and dir SHALL hold their levels, and IDLE SHALL NOT leave for POP. Pause SHALL NOT affect POP, WAIT, LOAD or FIN, which complete normally.
REQ-032 When the macro is undefined, the pause port SHALL be absent and the behaviour SHALL be identical to pause=0.

Verification
REQ-033 STEPS_PER_MOVE=4, HALF_PERIOD=3; FIFO holds code 3'b101 -> one fifo_rd pulse; dir[2]=1; 4 pulses on step[2], each 3 high/3 low; done once; move_cnt=1; busy for 28 cycles.
REQ-034 FIFO holds 3'b000, 3'b111 -> two fifo_rd pulses; step[0] pulses with dir[0]=0, then step[3] pulses with dir[3]=1; exactly one IDLE cycle between FIN and the second POP; move_cnt=2.
REQ-035 fifo_empty=1 for 100 cycles -> fifo_rd=0, busy=0, step=0 throughout.
REQ-036 rst asserted during the second STEP_HI of a move -> step=0, busy=0, move_cnt=0 in the same cycle; after release with fifo_empty=1, no activity.
REQ-037 MOVE_SEQUENCER_PAUSE_EN defined; pause=1 for 10 cycles mid-STEP_HI -> step stays high for HALF_PERIOD+10 cycles total; step count unchanged.
REQ-038 move_cnt preset path via 65536 moves (or forced) -> move_cnt wraps 65535->0 with done pulsing normally.

Source files
------------

// File: rtl/move_sequencer.sv
// Move sequencer: pops 3-bit move codes from a FIFO and drives step/dir pulse trains for four motors.
// Build option MOVE_SEQUENCER_PAUSE_EN adds a pause input that freezes stepping and new pops.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a non-empty FIFO
// POP     | one-cycle fifo_rd strobe
// WAIT    | FIFO output settles; code and dir captured on exit
// LOAD    | clear timer/counter, first step rises on exit
// STEP_HI | step[motor] high for HALF_PERIOD cycles
// STEP_LO | step low for HALF_PERIOD cycles, count the step on exit
// FIN     | one-cycle done pulse, move_cnt incremented
module move_sequencer #(
    parameter int DATO_WIDTH     = 3,
    parameter int STEPS_PER_MOVE = 50,
    parameter int HALF_PERIOD    = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATO_WIDTH-1:0] fifo_dat,
    input  logic                  fifo_empty,
`ifdef MOVE_SEQUENCER_PAUSE_EN
    input  logic                  pause,
`endif
    output logic                  fifo_rd,
    output logic [3:0]            step,
    output logic [3:0]            dir,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           move_cnt
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        POP     = 3'd1,
        WAIT    = 3'd2,
        LOAD    = 3'd3,
        STEP_HI = 3'd4,
        STEP_LO = 3'd5,
        FIN     = 3'd6
    } state_t;

    localparam logic [15:0] HP_LAST   = 16'(HALF_PERIOD - 1);
    localparam logic [15:0] STEP_LAST = 16'(STEPS_PER_MOVE - 1);

    state_t                state;
    logic [DATO_WIDTH-1:0] code;
    logic [15:0]           timer;
    logic [15:0]           step_cnt;
    logic [1:0]            motor;
    logic                  hold;

    assign motor = code[2:1];

`ifdef MOVE_SEQUENCER_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            fifo_rd  <= 1'b0;
            step     <= 4'b0;
            dir      <= 4'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            move_cnt <= 16'd0;
            code     <= '0;
            timer    <= 16'd0;
            step_cnt <= 16'd0;
        end else begin
            fifo_rd <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty && !hold) begin
                        state   <= POP;
                        fifo_rd <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                POP: begin
                    state <= WAIT;
                end
                WAIT: begin
                    // Latch on the way into LOAD so dir is stable a full cycle before step rises.
                    code                <= fifo_dat;
                    dir[fifo_dat[2:1]]  <= fifo_dat[0];
                    state               <= LOAD;
                end
                LOAD: begin
                    timer       <= 16'd0;
                    step_cnt    <= 16'd0;
                    step[motor] <= 1'b1;
                    state       <= STEP_HI;
                end
                STEP_HI: begin
                    if (!hold) begin
                        if (timer == HP_LAST) begin
                            timer <= 16'd0;
                            step  <= 4'b0;
                            state <= STEP_LO;
                        end else begin
                            timer <= timer + 16'd1;
                        end
                    end
                end
                STEP_LO: begin
                    if (!hold) begin
                        if (timer == HP_LAST) begin
                            timer    <= 16'd0;
                            step_cnt <= step_cnt + 16'd1;
                            if (step_cnt == STEP_LAST) begin
                                state    <= FIN;
                                done     <= 1'b1;
                                move_cnt <= move_cnt + 16'd1;
                            end else begin
                                step[motor] <= 1'b1;
                                state       <= STEP_HI;
                            end
                        end else begin
                            timer <= timer + 16'd1;
                        end
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_move_sequencer.sv
// Scoreboard bench for move_sequencer: stimulus pushes expected move results, a negedge monitor checks each done.
module tb_move_sequencer;

    localparam int DW       = 3;
    localparam int SPM      = 4;
    localparam int HP       = 3;
    localparam int BUSY_LEN = 3 + 2 * HP * SPM + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] fifo_dat = '0;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd;
    logic [3:0]    step;
    logic [3:0]    dir;
    logic          busy;
    logic          done;
    logic [15:0]   move_cnt;
`ifdef MOVE_SEQUENCER_PAUSE_EN
    logic          pause = 1'b0;
`endif

    typedef struct {
        int          motor;
        bit          dirbit;
        logic [15:0] cnt;
    } exp_t;

    exp_t          sb_q[$];
    logic [DW-1:0] fifo_q[$];
    int            checks = 0;
    int            errors = 0;
    int            rd_cnt = 0;
    bit            chk_width = 1'b1;

    move_sequencer #(
        .DATO_WIDTH    (DW),
        .STEPS_PER_MOVE(SPM),
        .HALF_PERIOD   (HP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_dat  (fifo_dat),
        .fifo_empty(fifo_empty),
`ifdef MOVE_SEQUENCER_PAUSE_EN
        .pause     (pause),
`endif
        .fifo_rd   (fifo_rd),
        .step      (step),
        .dir       (dir),
        .busy      (busy),
        .done      (done),
        .move_cnt  (move_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO model with registered read data: a read strobe presents the next entry one cycle later.
    always @(negedge clk) begin
        if (fifo_rd && fifo_q.size() > 0) fifo_dat = fifo_q.pop_front();
        fifo_empty = (fifo_q.size() == 0);
    end

    // Monitor
    int         busy_len = 0;
    int         hi_len = 0;
    int         lo_len = 0;
    bit         in_lo = 1'b0;
    int         pulses[4] = '{default: 0};
    logic [3:0] step_q = 4'b0;
    logic [3:0] dir_q = 4'b0;
    logic       rd_q = 1'b0;
    exp_t       mon_e;
    int         tot;

    always @(negedge clk) begin
        if (rst) begin
            busy_len = 0;
            hi_len   = 0;
            lo_len   = 0;
            in_lo    = 1'b0;
            for (int i = 0; i < 4; i++) pulses[i] = 0;
            step_q   = 4'b0;
            dir_q    = 4'b0;
            rd_q     = 1'b0;
        end else begin
            if (busy) busy_len++;
            if (fifo_rd) begin
                rd_cnt++;
                check("rd_while_busy", 32'(busy), 32'd1);
                check("rd_single_cycle", 32'(rd_q), 32'd0);
            end
            if ((|step) && (|step_q)) check("dir_stable_while_step", 32'(dir), 32'(dir_q));
            if (done) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pending move at %0t", $time);
                end else begin
                    mon_e = sb_q.pop_front();
                    tot = pulses[0] + pulses[1] + pulses[2] + pulses[3];
                    check("move_cnt", 32'(move_cnt), 32'(mon_e.cnt));
                    check("dir_bit", 32'(dir[mon_e.motor]), 32'(mon_e.dirbit));
                    check("step_pulses", 32'(pulses[mon_e.motor]), 32'(SPM));
                    check("other_pulses", 32'(tot - pulses[mon_e.motor]), 32'd0);
                    check("busy_len", 32'(busy_len), 32'(BUSY_LEN));
                    check("last_lo_width", 32'(lo_len), 32'(HP));
                end
                busy_len = 0;
                in_lo    = 1'b0;
                lo_len   = 0;
                for (int i = 0; i < 4; i++) pulses[i] = 0;
            end else if (|step) begin
                if (!(|step_q)) begin
                    if (in_lo) check("lo_width", 32'(lo_len), 32'(HP));
                    in_lo  = 1'b0;
                    hi_len = 1;
                    for (int i = 0; i < 4; i++) if (step[i]) pulses[i]++;
                end else begin
                    hi_len++;
                end
            end else if (|step_q) begin
                if (chk_width) check("hi_width", 32'(hi_len), 32'(HP));
                in_lo  = 1'b1;
                lo_len = 1;
            end else if (in_lo) begin
                lo_len++;
            end
            step_q = step;
            dir_q  = dir;
            rd_q   = fifo_rd;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic push(input logic [2:0] code, input bit expect_done, input logic [15:0] cnt);
        exp_t e;
        fifo_q.push_back(code);
        if (expect_done) begin
            e.motor  = int'(code[2:1]);
            e.dirbit = code[0];
            e.cnt    = cnt;
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 400);
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s: got no done within %0d cycles expected done", name, n);
        end
    endtask

    initial begin
        int r0;
        int n;
        int viol;
        int rises;
        int hi;
        bit prev;
        bit hi_now;

        // reset values while rst is held
        @(negedge clk);
        check("rst_fifo_rd", 32'(fifo_rd), 32'd0);
        check("rst_step", 32'(step), 32'd0);
        check("rst_dir", 32'(dir), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_move_cnt", 32'(move_cnt), 32'd0);
        #2 rst = 1'b0;

        // single move, motor 2 clockwise
        do_reset();
        r0 = rd_cnt;
        push(3'b101, 1'b1, 16'd1);
        wait_done("move_single");
        check("single_rd_pulses", 32'(rd_cnt - r0), 32'd1);
        check("single_dir", 32'(dir), 32'h4);
        repeat (10) @(negedge clk);
        check("single_busy_after", 32'(busy), 32'd0);
        check("single_move_cnt", 32'(move_cnt), 32'd1);

        // back-to-back moves
        do_reset();
        r0 = rd_cnt;
        push(3'b000, 1'b1, 16'd1);
        push(3'b111, 1'b1, 16'd2);
        wait_done("move_b2b_a");
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fifo_rd && n < 10);
        check("b2b_gap", 32'(n), 32'd2);
        wait_done("move_b2b_b");
        check("b2b_dir", 32'(dir), 32'h8);
        check("b2b_rd_pulses", 32'(rd_cnt - r0), 32'd2);
        check("b2b_move_cnt", 32'(move_cnt), 32'd2);

        // empty FIFO stays quiet
        do_reset();
        viol = 0;
        repeat (100) begin
            @(negedge clk);
            if (fifo_rd || busy || step != 4'b0) viol++;
        end
        check("idle_quiet", 32'(viol), 32'd0);

        // reset during the second STEP_HI
        do_reset();
        push(3'b101, 1'b1, 16'd1);
        wait_done("move_pre_rst");
        push(3'b011, 1'b0, 16'd0);
        rises = 0;
        n = 0;
        prev = 1'b0;
        while (rises < 2 && n < 200) begin
            @(negedge clk);
            n++;
            if (step[1] && !prev) rises++;
            prev = step[1];
        end
        check("rst_mid_reached_2nd_hi", 32'(rises), 32'd2);
        check("rst_mid_dir_before", 32'(dir), 32'h6);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_step", 32'(step), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_move_cnt", 32'(move_cnt), 32'd0);
        check("rst_mid_dir", 32'(dir), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        viol = 0;
        repeat (30) begin
            @(negedge clk);
            if (fifo_rd || busy || done || step != 4'b0) viol++;
        end
        check("rst_mid_no_resume", 32'(viol), 32'd0);

        // move_cnt wrap 65535 -> 0
        do_reset();
        @(negedge clk);
        force dut.move_cnt = 16'hffff;
        @(negedge clk);
        release dut.move_cnt;
        push(3'b110, 1'b1, 16'd0);
        push(3'b010, 1'b1, 16'd1);
        wait_done("move_wrap_a");
        wait_done("move_wrap_b");
        check("wrap_move_cnt", 32'(move_cnt), 32'd1);

`ifdef MOVE_SEQUENCER_PAUSE_EN
        // pause for 10 cycles inside a STEP_HI, then pause blocking a pop in IDLE
        do_reset();
        chk_width = 1'b0;
        push(3'b001, 1'b1, 16'd1);
        n = 0;
        while (!step[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        hi = step[0] ? 1 : 0;
        @(negedge clk);
        if (step[0]) hi++;
        pause = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (step[0]) hi++;
        end
        pause = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            hi_now = step[0];
            if (hi_now) hi++;
        end while (hi_now && n < 50);
        check("pause_hi_len", 32'(hi), 32'(HP + 10));
        wait_done("move_pause");
        chk_width = 1'b1;
        pause = 1'b1;
        push(3'b100, 1'b1, 16'd2);
        viol = 0;
        repeat (20) begin
            @(negedge clk);
            if (fifo_rd || busy) viol++;
        end
        check("pause_blocks_pop", 32'(viol), 32'd0);
        pause = 1'b0;
        wait_done("move_after_pause");
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
